// File: rtl/sdram_writer_pkg.sv
// rtl/sdram_writer_pkg.sv - shared constants and FSM state type for the SDRAM write master
package sdram_writer_pkg;
    localparam int INTERFACE_WIDTH_BITS  = 128;
    localparam int INTERFACE_WIDTH_BYTES = INTERFACE_WIDTH_BITS / 8;
    localparam int INTERFACE_ADDR_BITS   = 26;
    localparam int LEN_BITS              = 16;
    localparam int LANE_BITS             = $clog2(INTERFACE_WIDTH_BYTES);
    localparam int WORD_ADDR_INC         = 16;
    localparam int TIMEOUT_CYCLES        = 255;
    localparam int TIMEOUT_BITS          = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/sdram_writer_if.sv
// rtl/sdram_writer_if.sv - byte stream input and Avalon bridge write bus bundle
interface sdram_writer_if;
    import sdram_writer_pkg::*;

    logic [7:0]                       in_data;
    logic                             in_valid;
    logic                             in_ready;
    logic [INTERFACE_ADDR_BITS-1:0]   address;
    logic [INTERFACE_WIDTH_BYTES-1:0] byte_enable;
    logic                             write;
    logic                             read;
    logic [INTERFACE_WIDTH_BITS-1:0]  write_data;
    logic                             acknowledge;

    modport master (
        input  in_data, in_valid, acknowledge,
        output in_ready, address, byte_enable, write, read, write_data
    );

    modport slave (
        output in_data, in_valid, acknowledge,
        input  in_ready, address, byte_enable, write, read, write_data
    );
endinterface

// File: rtl/sdram_writer_byte_packer.sv
// rtl/sdram_writer_byte_packer.sv - little-endian byte-to-word lane packer
module sdram_writer_byte_packer
    import sdram_writer_pkg::*;
(
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_accept,
    input  logic [7:0]                       i_byte,
    input  logic                             i_last_byte,
    input  logic                             i_clear,
    output logic [INTERFACE_WIDTH_BITS-1:0]  o_data,
    output logic [INTERFACE_WIDTH_BYTES-1:0] o_byte_enable,
    output logic                             o_complete
);
    logic [LANE_BITS-1:0]             r_lane;
    logic [INTERFACE_WIDTH_BITS-1:0]  r_data;
    logic [INTERFACE_WIDTH_BYTES-1:0] r_byte_enable;

    // A word closes on its top lane or on the final byte of the transfer
    assign o_complete    = i_accept && ((r_lane == LANE_BITS'(INTERFACE_WIDTH_BYTES - 1)) || i_last_byte);
    assign o_data        = r_data;
    assign o_byte_enable = r_byte_enable;

    // Drop each accepted byte into the current lane; clearing leaves unused lanes zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane        <= '0;
            r_data        <= '0;
            r_byte_enable <= '0;
        end else if (i_clear) begin
            r_lane        <= '0;
            r_data        <= '0;
            r_byte_enable <= '0;
        end else if (i_accept) begin
            r_data[{r_lane, 3'b000} +: 8] <= i_byte;
            r_byte_enable[r_lane]         <= 1'b1;
            r_lane                        <= r_lane + 1'b1;
        end
    end
endmodule

// File: rtl/sdram_writer.sv
// rtl/sdram_writer.sv - byte stream to 128-bit bridge write master; optional SDRAM_WRITER_TIMEOUT_EN
module sdram_writer
    import sdram_writer_pkg::*;
(
    input  logic                           i_interface_clock,
    input  logic                           i_reset_n,
    input  logic                           i_start,
    input  logic [INTERFACE_ADDR_BITS-1:0] i_base_address,
    input  logic [LEN_BITS-1:0]            i_num_bytes,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_timing_error,
    input  logic                           i_timing_error_reset,
    sdram_writer_if.master                 bus
);
    state_t                           r_state;
    logic [INTERFACE_ADDR_BITS-1:0]   r_address;
    logic [LEN_BITS-1:0]              r_remaining;
    logic                             r_busy;
    logic                             r_done;
    logic                             r_in_ready;
    logic                             r_write;
    logic                             w_accept;
    logic                             w_ack;
    logic                             w_word_complete;
    logic [INTERFACE_WIDTH_BITS-1:0]  w_data;
    logic [INTERFACE_WIDTH_BYTES-1:0] w_byte_enable;

    assign w_accept = (r_state == ST_FILL) && r_in_ready && bus.in_valid;
    assign w_ack    = (r_state == ST_WRITE) && bus.acknowledge;

    sdram_writer_byte_packer u_packer (
        .i_clk         (i_interface_clock),
        .i_rst_n       (i_reset_n),
        .i_accept      (w_accept),
        .i_byte        (bus.in_data),
        .i_last_byte   (r_remaining == LEN_BITS'(1)),
        .i_clear       (w_ack),
        .o_data        (w_data),
        .o_byte_enable (w_byte_enable),
        .o_complete    (w_word_complete)
    );

    // Transfer sequencer: fill a word, hold the write until acknowledged, repeat until the count runs out
    always_ff @(posedge i_interface_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_address   <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_write     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_address   <= i_base_address & ~INTERFACE_ADDR_BITS'(WORD_ADDR_INC - 1);
                        r_remaining <= i_num_bytes;
                        r_busy      <= 1'b1;
                        r_state     <= (i_num_bytes == '0) ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (w_word_complete) begin
                            r_in_ready <= 1'b0;
                            r_write    <= 1'b1;
                            r_state    <= ST_WRITE;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_ack) begin
                        r_write   <= 1'b0;
                        r_address <= r_address + INTERFACE_ADDR_BITS'(WORD_ADDR_INC);
                        r_state   <= (r_remaining != '0) ? ST_FILL : ST_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign bus.in_ready     = r_in_ready;
    assign bus.write        = r_write;
    assign bus.read         = 1'b0;
    assign bus.address      = r_address;
    assign bus.write_data   = w_data;
    assign bus.byte_enable  = w_byte_enable;

`ifdef SDRAM_WRITER_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] r_timeout_count;
    logic                    r_timing_error;

    // Count unacknowledged WRITE cycles, saturating so one stall flags only once
    always_ff @(posedge i_interface_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_timeout_count <= '0;
        end else if ((r_state == ST_WRITE) && !bus.acknowledge) begin
            if (r_timeout_count != TIMEOUT_BITS'(TIMEOUT_CYCLES))
                r_timeout_count <= r_timeout_count + 1'b1;
        end else begin
            r_timeout_count <= '0;
        end
    end

    // Sticky timeout flag; a set coinciding with a clear request wins
    always_ff @(posedge i_interface_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_timing_error <= 1'b0;
        else if ((r_state == ST_WRITE) && !bus.acknowledge &&
                 (r_timeout_count == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1)))
            r_timing_error <= 1'b1;
        else if (i_timing_error_reset)
            r_timing_error <= 1'b0;
    end

    assign o_timing_error = r_timing_error;
`else
    logic w_unused_timing_error_reset;
    assign w_unused_timing_error_reset = i_timing_error_reset;
    assign o_timing_error              = 1'b0;
`endif
endmodule
